memmgr: RTL and testbench

MEMMGR -- requirements
Module: memmgr

---
 rtl/memmgr.sv | 145 ++++++++++++++
 tb/tb_memmgr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memmgr.sv
// memmgr: UART-driven memory loader and register dumper for a small core.
// Receives a 24-bit little-endian length, then streams that many bytes into
// memory, hands the bus to the core, and on cede optionally dumps x0..x31.
// Optional feature macro: MEMMGR_DUMP_EN (builds the register-dump state).
module memmgr #(
    parameter int MABL = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    output logic            state,
    input  logic            cede,
    input  logic            core_we,
    input  logic [7:0]      core_wd,
    input  logic [MABL-1:0] core_ad,
    output logic            mem_we,
    output logic [7:0]      mem_wd,
    output logic [MABL-1:0] mem_ad,
    output logic [4:0]      memmgr_ra1,
    input  logic [31:0]     rd1
);
    typedef enum logic [1:0] {LEN, LOAD, RUN, DUMP} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [23:0]     len_q, len_d;     // requested byte count N
    logic [1:0]      lidx_q, lidx_d;   // which length byte comes next
    logic [23:0]     lcnt_q, lcnt_d;   // bytes loaded so far (full width, never truncated)
    logic [MABL-1:0] ladr_q, ladr_d;   // load address, wraps at 2^MABL
    logic            state_q;
`ifdef MEMMGR_DUMP_EN
    logic [6:0]      dcnt_q, dcnt_d;   // dump byte counter: [6:2] register, [1:0] byte
`else
    logic            unused_dump_inputs;
    assign unused_dump_inputs = ^{rd1, tx_ready};
`endif

    assign state = state_q;

    // State and counter registers; reset aborts any load or dump at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= LEN;
            len_q   <= '0;
            lidx_q  <= '0;
            lcnt_q  <= '0;
            ladr_q  <= '0;
            state_q <= 1'b0;
`ifdef MEMMGR_DUMP_EN
            dcnt_q  <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            len_q   <= len_d;
            lidx_q  <= lidx_d;
            lcnt_q  <= lcnt_d;
            ladr_q  <= ladr_d;
            state_q <= (fsm_d == RUN);
`ifdef MEMMGR_DUMP_EN
            dcnt_q  <= dcnt_d;
`endif
        end
    end

    // Next-state, counter updates and bus/tx muxing.
    always_comb begin
        fsm_d      = fsm_q;
        len_d      = len_q;
        lidx_d     = lidx_q;
        lcnt_d     = lcnt_q;
        ladr_d     = ladr_q;
        mem_we     = 1'b0;
        mem_wd     = '0;
        mem_ad     = '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        memmgr_ra1 = '0;
`ifdef MEMMGR_DUMP_EN
        dcnt_d     = dcnt_q;
`endif
        case (fsm_q)
            LEN: begin
                if (rx_valid) begin
                    case (lidx_q)
                        2'd0:    len_d[7:0]   = rx_data;
                        2'd1:    len_d[15:8]  = rx_data;
                        default: len_d[23:16] = rx_data;
                    endcase
                    if (lidx_q == 2'd2) begin
                        lidx_d = '0;
                        fsm_d  = (len_d == 24'd0) ? RUN : LOAD;
                    end else begin
                        lidx_d = lidx_q + 2'd1;
                    end
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    mem_we = 1'b1;
                    mem_wd = rx_data;
                    mem_ad = ladr_q;
                    ladr_d = ladr_q + MABL'(1);
                    lcnt_d = lcnt_q + 24'd1;
                    if (lcnt_d == len_q)
                        fsm_d = RUN;
                end
            end
            RUN: begin
                mem_we = core_we;
                mem_wd = core_wd;
                mem_ad = core_ad;
                if (cede) begin
                    // Leave with a clean slate so the next session starts at length byte 0.
                    len_d  = '0;
                    lidx_d = '0;
                    lcnt_d = '0;
                    ladr_d = '0;
`ifdef MEMMGR_DUMP_EN
                    dcnt_d = '0;
                    fsm_d  = DUMP;
`else
                    fsm_d  = LEN;
`endif
                end
            end
`ifdef MEMMGR_DUMP_EN
            DUMP: begin
                // Core is halted, so rd1 is steady for a fixed index: tx_data holds while stalled.
                tx_valid   = 1'b1;
                memmgr_ra1 = dcnt_q[6:2];
                tx_data    = rd1[{dcnt_q[1:0], 3'b000} +: 8];
                if (tx_ready) begin
                    dcnt_d = dcnt_q + 7'd1;
                    if (dcnt_q == 7'd127)
                        fsm_d = LEN;
                end
            end
`endif
            default: fsm_d = LEN;
        endcase
    end
endmodule

// File: tb/tb_memmgr.sv
// Self-checking bench for memmgr: scoreboard of expected memory writes and
// dump bytes, a vector table for the RUN pass-through, and hand-written
// sequences for length/load, reset abort, address wrap and cede.
module tb_memmgr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        cede;
    logic        core_we;
    logic [7:0]  core_wd;
    logic [18:0] core_ad;

    logic        tx_valid, state, mem_we;
    logic [7:0]  tx_data, mem_wd;
    logic [18:0] mem_ad;
    logic [4:0]  ra1;
    logic [31:0] rd1;

    logic        tx_valid4, state4, mem_we4;
    logic [7:0]  tx_data4, mem_wd4;
    logic [3:0]  mem_ad4;
    logic [4:0]  ra14;
    logic [31:0] rd14;

    typedef struct { logic [18:0] ad; logic [7:0] wd; } wr_t;
    typedef struct {
        logic we; logic [7:0] wd; logic [18:0] ad; logic rxv;
        logic exp_we; logic [7:0] exp_wd; logic [18:0] exp_ad;
    } vec_t;

    wr_t        q[$];
    wr_t        q4[$];
    logic [7:0] txq[$];
    int         nchk = 0;
    int         nfail = 0;
    int         nwr = 0;
    logic       any_txv = 1'b0;

    always #5 clk = ~clk;

    memmgr #(.MABL(19)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .state(state),
        .cede(cede), .core_we(core_we), .core_wd(core_wd), .core_ad(core_ad),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_ad(mem_ad),
        .memmgr_ra1(ra1), .rd1(rd1)
    );

    memmgr #(.MABL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid4), .tx_ready(tx_ready), .tx_data(tx_data4), .state(state4),
        .cede(cede), .core_we(core_we), .core_wd(core_wd), .core_ad(core_ad[3:0]),
        .mem_we(mem_we4), .mem_wd(mem_wd4), .mem_ad(mem_ad4),
        .memmgr_ra1(ra14), .rd1(rd14)
    );

    // Register file model: x1 holds the known pattern, others a per-index pattern.
    function automatic logic [31:0] regval(logic [4:0] r);
        return (r == 5'd1) ? 32'h12345678 : {4{3'b000, r}};
    endfunction
    assign rd1  = regval(ra1);
    assign rd14 = regval(ra14);

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_w(logic [18:0] ad, logic [7:0] wd);
        q.push_back('{ad, wd});
        q4.push_back('{ad, wd});
    endtask

    task automatic send_rx(logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic send_len(logic [23:0] n);
        send_rx(n[7:0]); send_rx(n[15:8]); send_rx(n[23:16]);
    endtask

    task automatic load_byte(logic [18:0] ad, logic [7:0] b);
        push_w(ad, b);
        send_rx(b);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic pulse_cede();
        @(posedge clk); #1 cede = 1'b1;
        @(posedge clk); #1 cede = 1'b0;
    endtask

    // Write scoreboard for both instances; every mem_we must match a queued entry.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            nwr++;
            if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("wr_ad", 32'(mem_ad), 32'(e.ad));
                chk("wr_wd", 32'(mem_wd), 32'(e.wd));
            end
        end
        if (mem_we4) begin
            if (q4.size() == 0) chk("unexpected_write4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("wr4_ad", 32'(mem_ad4), 32'(e.ad[3:0]));
                chk("wr4_wd", 32'(mem_wd4), 32'(e.wd));
            end
        end
        if (tx_valid || tx_valid4) any_txv = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        int   wbase;
        int   acc;
        logic stall;
        logic [7:0] held;

        vecs[0] = '{1'b1, 8'h5A, 19'd5,       1'b0, 1'b1, 8'h5A, 19'd5};
        vecs[1] = '{1'b0, 8'h33, 19'd7,       1'b1, 1'b0, 8'h33, 19'd7};
        vecs[2] = '{1'b1, 8'hFF, 19'h7FFFF,   1'b1, 1'b1, 8'hFF, 19'h7FFFF};
        vecs[3] = '{1'b1, 8'h00, 19'd0,       1'b0, 1'b1, 8'h00, 19'd0};

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        cede = 1'b0; core_we = 1'b0; core_wd = '0; core_ad = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_ra1", 32'(ra1), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Length 3, three loads, then RUN
        send_len(24'd3);
        @(negedge clk);
        chk("state_in_load", 32'(state), 32'd0);
        load_byte(19'd0, 8'hAA);
        load_byte(19'd1, 8'hBB);
        load_byte(19'd2, 8'hCC);
        @(negedge clk);
        chk("state_after_load", 32'(state), 32'd1);
        chk("load_write_count", 32'(nwr), 32'd3);

        // RUN: core bus passes through, rx ignored
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            core_we = vecs[i].we; core_wd = vecs[i].wd; core_ad = vecs[i].ad;
            rx_valid = vecs[i].rxv; rx_data = 8'h99;
            if (vecs[i].exp_we) push_w(vecs[i].exp_ad, vecs[i].exp_wd);
            @(negedge clk);
            chk("run_we", 32'(mem_we), 32'(vecs[i].exp_we));
            chk("run_wd", 32'(mem_wd), 32'(vecs[i].exp_wd));
            chk("run_ad", 32'(mem_ad), 32'(vecs[i].exp_ad));
            chk("run_state", 32'(state), 32'd1);
        end
        @(posedge clk); #1 core_we = 1'b0; core_wd = '0; core_ad = '0; rx_valid = 1'b0;

`ifdef MEMMGR_DUMP_EN
        // Dump with tx_ready stalled every other cycle
        for (int i = 0; i < 128; i++) begin
            logic [31:0] v;
            v = regval(5'(i / 4));
            txq.push_back(v[(i % 4) * 8 +: 8]);
        end
        pulse_cede();
        @(negedge clk);
        chk("state_after_cede", 32'(state), 32'd0);
        chk("dump_tx_valid", 32'(tx_valid), 32'd1);
        acc = 0; stall = 1'b0; held = '0;
        for (int c = 0; c < 1000 && acc < 128; c++) begin
            @(posedge clk); #1 tx_ready = c[0];
            @(negedge clk);
            if (stall) chk("tx_hold", 32'(tx_data), 32'(held));
            if (tx_ready) begin
                chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
                acc++;
                stall = 1'b0;
            end else begin
                held  = tx_data;
                stall = 1'b1;
            end
        end
        @(posedge clk); #1 tx_ready = 1'b0;
        chk("dump_count", 32'(acc), 32'd128);
        @(negedge clk);
        chk("post_dump_tx_valid", 32'(tx_valid), 32'd0);
        chk("post_dump_state", 32'(state), 32'd0);
        chk("post_dump_ra1", 32'(ra1), 32'd0);
`else
        pulse_cede();
        @(negedge clk);
        chk("state_after_cede", 32'(state), 32'd0);
        chk("nodump_tx_valid", 32'(tx_valid), 32'd0);
`endif

        // Zero length goes straight to RUN with no writes
        wbase = nwr;
        send_len(24'd0);
        @(negedge clk);
        chk("zero_len_state", 32'(state), 32'd1);
        chk("zero_len_writes", 32'(nwr), 32'(wbase));

        // Reset mid-load aborts; next stream starts fresh
        pulse_reset();
        send_len(24'd4);
        load_byte(19'd0, 8'h11);
        load_byte(19'd1, 8'h22);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h33;
        #1 chk("we_before_rst", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1 chk("we_in_rst", 32'(mem_we), 32'd0);
        chk("state_in_rst", 32'(state), 32'd0);
        @(posedge clk); #1 rx_valid = 1'b0; rst_n = 1'b1;
        send_len(24'd1);
        load_byte(19'd0, 8'hEE);
        @(negedge clk);
        chk("after_abort_state", 32'(state), 32'd1);

        // N=18: the MABL=4 instance wraps bytes 16,17 to addresses 0,1
        pulse_reset();
        send_len(24'd18);
        for (int i = 0; i < 18; i++) load_byte(19'(i), 8'(8'h40 + i));
        @(negedge clk);
        chk("n18_state", 32'(state), 32'd1);
        chk("n18_state4", 32'(state4), 32'd1);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("queue4_drained", 32'(q4.size()), 32'd0);
`ifndef MEMMGR_DUMP_EN
        chk("tx_valid_never", 32'(any_txv), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
